aes_dec_stream_wrapper: RTL and testbench

//  Streaming front-end for the iterative inverse-AES core: accepts 128-bit ciphertext blocks over

---
 rtl/aes_dec_stream_wrapper_if.sv | 22 ++
 rtl/aes_dec_stream_wrapper.sv | 100 ++++++++++
 tb/tb_aes_dec_stream_wrapper.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_stream_wrapper_if.sv
// aes_dec_stream_wrapper_if: ciphertext stream in, plaintext stream out, inverse-AES core handshake
interface aes_dec_stream_wrapper_if;
  logic in_valid;
  logic in_ready;
  logic [127:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [127:0] out_data;
  logic core_start;
  logic [127:0] core_text;
  logic [127:0] core_key;
  logic core_done;
  logic [127:0] core_data;
  modport slave (
    input in_valid, in_data, out_ready, core_done, core_data,
    output in_ready, out_valid, out_data, core_start, core_text, core_key
  );
  modport master (
    output in_valid, in_data, out_ready, core_done, core_data,
    input in_ready, out_valid, out_data, core_start, core_text, core_key
  );
endinterface

// File: rtl/aes_dec_stream_wrapper.sv
// aes_dec_stream_wrapper: buffered valid/ready front-end issuing blocks to an iterative inverse-AES core
module aes_dec_stream_wrapper #(
  parameter int DEPTH = 4,
  parameter bit CBC_EN = 1'b1,
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rest,
  input  logic mode,
  input  logic [127:0] key_in,
  input  logic key_load,
  input  logic [127:0] iv_in,
  input  logic iv_load,
  aes_dec_stream_wrapper_if.slave bus,
  output logic err,
  output logic [CNT_W-1:0] blk_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DRAIN} state_t;
  state_t state, state_n;
  logic [127:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [127:0] key, chain, ct;
  logic [TW-1:0] tmr;
  logic mode_q, done_q, rise, push, pop, idle_empty, fire, expire;
  assign bus.in_ready = !rest && cnt != (AW+1)'(DEPTH);
  assign push = bus.in_valid & bus.in_ready;
  assign rise = bus.core_done & ~done_q;
  assign idle_empty = state == IDLE && cnt == '0;
  assign fire = state == WAIT && rise;
  assign expire = state == WAIT && !rise && tmr == TW'(TIMEOUT);
  assign bus.out_valid = state == OUT;
  assign bus.core_start = state == WAIT;
  assign bus.core_text = ct;
  assign bus.core_key = key;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = cnt != '0;
        state_n = pop ? ISSUE : IDLE;
      end
      ISSUE: state_n = WAIT;
      WAIT: state_n = fire ? OUT : expire ? DRAIN : WAIT;
      OUT: if (bus.out_ready) begin
        pop = cnt != '0;
        state_n = pop ? ISSUE : IDLE;
      end
      DRAIN: state_n = bus.core_done ? DRAIN : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rest) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= bus.in_data;
  end
  always_ff @(posedge clk) begin
    if (rest) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      key <= '0;
      chain <= '0;
      ct <= '0;
      tmr <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      err <= 1'b0;
      blk_count <= '0;
      bus.out_data <= '0;
    end else begin
      done_q <= bus.core_done;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      tmr <= state == WAIT ? tmr + 1'b1 : '0;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        ct <= mem[rp];
        rp <= rp + 1'b1;
      end
      if (idle_empty) begin
        mode_q <= CBC_EN & mode;
        if (key_load) key <= key_in;
        if (iv_load) chain <= iv_in;
      end
      if (fire) begin
        bus.out_data <= bus.core_data ^ (mode_q ? chain : '0);
        chain <= ct;
      end
      if (expire) err <= 1'b1;
      if (state == OUT && bus.out_ready) blk_count <= blk_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_aes_dec_stream_wrapper.sv
// tb_aes_dec_stream_wrapper: scoreboard bench with a table-driven inverse-AES core model
module tb_aes_dec_stream_wrapper;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 64;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h29c3505f5714231a02d73a0f6402299b;
  localparam logic [127:0] P2 = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Q1 = 128'h3242f4ab8c5f368a393892a9ec3a093b;
  localparam logic [127:0] Q2 = 128'h6d52eb3d4db26cdb9278ebf2393e7c5d;
  logic clk = 1'b0;
  logic rest, mode, key_load, iv_load, err;
  logic [127:0] key_in, iv_in;
  logic [15:0] blk_count;
  logic hang, stale;
  int total = 0;
  int bad = 0;
  logic [127:0] exp_q[$];
  aes_dec_stream_wrapper_if bus();
  aes_dec_stream_wrapper #(.DEPTH(DEPTH), .CBC_EN(1'b1), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rest(rest), .mode(mode), .key_in(key_in), .key_load(key_load),
    .iv_in(iv_in), .iv_load(iv_load), .bus(bus), .err(err), .blk_count(blk_count)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] dec(input logic [127:0] c);
    if (c == C1) return P1;
    if (c == C2) return P2;
    return {c[63:0], c[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
  endfunction
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [127:0] d);
    logic r;
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    forever begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 200) begin
        check("push accepted", 128'(r), 128'd1);
        break;
      end
    end
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard drained", 128'(exp_q.size()), 128'd0);
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_start();
    for (int i = 0; i < 100 && !bus.core_start; i++) @(negedge clk);
    check("core_start seen", 128'(bus.core_start), 128'd1);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // core model: done a few cycles after start, held until start drops
  initial begin
    int w = 0;
    bus.core_done = 1'b0;
    bus.core_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (hang) begin
        bus.core_done = stale;
        bus.core_data = stale ? 128'hdeadbeef_deadbeef_deadbeef_deadbeef : '0;
        w = 0;
      end else if (bus.core_start && !bus.core_done) begin
        w++;
        if (w >= 3) begin
          bus.core_done = 1'b1;
          bus.core_data = dec(bus.core_text);
          w = 0;
        end
      end else if (!bus.core_start) bus.core_done = 1'b0;
    end
  end
  initial begin
    logic stall = 1'b0;
    logic [127:0] hold_d = '0;
    forever begin
      @(negedge clk);
      if (!rest && bus.out_valid) begin
        if (stall) check("out_data hold", bus.out_data, hold_d);
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected output: got %h want none", bus.out_data);
          end else check("out_data", bus.out_data, exp_q.pop_front());
        end
      end
      stall = !rest && bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    logic [127:0] d [6];
    logic r;
    int acc;
    rest = 1'b1; mode = 1'b0; key_load = 1'b0; iv_load = 1'b0;
    key_in = '0; iv_in = '0; hang = 1'b0; stale = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) d[i] = {32'hc0de0000 + 32'(i), 32'h11111111 * 32'(i + 1), 64'h0123456789abcdef};
    repeat (3) @(negedge clk);
    check("in_ready in reset", 128'(bus.in_ready), 128'd0);
    cyc();
    rest = 1'b0;
    @(negedge clk);
    check("in_ready after reset", 128'(bus.in_ready), 128'd1);
    check("out_valid reset", 128'(bus.out_valid), 128'd0);
    check("out_data reset", bus.out_data, '0);
    check("core_start reset", 128'(bus.core_start), 128'd0);
    check("err reset", 128'(err), 128'd0);
    check("blk_count reset", 128'(blk_count), 128'd0);
    check("core_key reset", bus.core_key, '0);
    cyc();
    key_in = K1; key_load = 1'b1;
    cyc();
    key_load = 1'b0;
    @(negedge clk);
    check("core_key loaded", bus.core_key, K1);
    // ECB single block, with start latency
    cyc();
    exp_q.push_back(P1);
    push(C1);
    @(negedge clk);
    check("start lat +1", 128'(bus.core_start), 128'd0);
    @(negedge clk);
    check("start lat +2 early", 128'(bus.core_start), 128'd0);
    @(negedge clk);
    check("start lat +2", 128'(bus.core_start), 128'd1);
    check("core_text", bus.core_text, C1);
    drain();
    check("blk_count ecb", 128'(blk_count), 128'd1);
    // ECB back-to-back
    cyc();
    exp_q.push_back(P1);
    exp_q.push_back(P2);
    push(C1);
    push(C2);
    drain();
    check("blk_count b2b", 128'(blk_count), 128'd3);
    // CBC, with ignored loads/mode change while busy
    cyc();
    mode = 1'b1; iv_in = IV; iv_load = 1'b1;
    cyc();
    iv_load = 1'b0;
    exp_q.push_back(Q1);
    exp_q.push_back(Q2);
    push(C1);
    push(C2);
    iv_in = '1; iv_load = 1'b1; key_in = '1; key_load = 1'b1; mode = 1'b0;
    cyc();
    iv_load = 1'b0; key_load = 1'b0; mode = 1'b1;
    drain();
    check("key unchanged when busy", bus.core_key, K1);
    check("blk_count cbc", 128'(blk_count), 128'd5);
    cyc();
    mode = 1'b0;
    cyc();
    // backpressure and FIFO full
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = d[acc];
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      if (r) begin
        exp_q.push_back(dec(d[acc]));
        acc++;
      end
      #1;
    end
    bus.in_valid = 1'b0;
    check("accepted before full", 128'(acc), 128'(DEPTH + 1));
    @(negedge clk);
    check("in_ready when full", 128'(bus.in_ready), 128'd0);
    repeat (10) @(negedge clk);
    check("out_valid stalled", 128'(bus.out_valid), 128'd1);
    check("out_data stalled", bus.out_data, dec(d[0]));
    cyc();
    bus.out_ready = 1'b1;
    exp_q.push_back(dec(d[5]));
    push(d[5]);
    drain();
    check("blk_count full", 128'(blk_count), 128'd11);
    // core hang timeout
    cyc();
    hang = 1'b1;
    push(d[1]);
    wait_start();
    repeat (TIMEOUT) @(negedge clk);
    check("err before timeout", 128'(err), 128'd0);
    @(negedge clk);
    check("err at timeout", 128'(err), 128'd1);
    check("core_start after timeout", 128'(bus.core_start), 128'd0);
    repeat (3) @(negedge clk);
    cyc();
    hang = 1'b0;
    exp_q.push_back(P1);
    push(C1);
    drain();
    check("blk_count after timeout", 128'(blk_count), 128'd12);
    check("err sticky", 128'(err), 128'd1);
    // reset mid-WAIT followed by stale done
    cyc();
    hang = 1'b1;
    push(d[2]);
    wait_start();
    cyc();
    rest = 1'b1;
    cyc();
    rest = 1'b0;
    stale = 1'b1;
    repeat (5) cyc();
    stale = 1'b0;
    repeat (2) @(negedge clk);
    check("out_valid after stale done", 128'(bus.out_valid), 128'd0);
    check("core_start after reset", 128'(bus.core_start), 128'd0);
    check("in_ready after mid reset", 128'(bus.in_ready), 128'd1);
    check("blk_count after mid reset", 128'(blk_count), 128'd0);
    check("err cleared by reset", 128'(err), 128'd0);
    cyc();
    hang = 1'b0;
    exp_q.push_back(P1);
    push(C1);
    drain();
    check("blk_count post reset", 128'(blk_count), 128'd1);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
